serial_parity_unit: RTL and testbench

Serial parity generator placed directly upstream of the two-input exclusive-disjunction (XOR) stage. It accepts a parallel word through a valid/ready handshake and presents one data bit per clock to the XOR stage as `ser_bit`. It folds each bit into a running parity accumulator and reports the word's even-parity bit with a one-cycle valid pulse. This is the first sequential block in the guide series.

---
 rtl/serial_parity_unit.sv | 143 ++++++++++++++
 tb/tb_serial_parity_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_parity_unit.sv
// serial_parity_unit: accepts a parallel word over a valid/ready handshake,
// presents it one bit per clock (LSB first) on ser_bit, and folds each bit
// into a running parity accumulator. The word's even-parity bit is reported
// on par_bit with a one-cycle par_valid pulse.
//
// Optional feature (macro PARITY_CHECK_EN): adds an in_par input and a
// registered par_err output. par_err flags a mismatch between the computed
// parity and the expected parity sampled with the word.
module serial_parity_unit #(
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
`ifdef PARITY_CHECK_EN
  input  logic                         in_par,
  output logic                         par_err,
`endif
  output logic                         ser_bit,
  output logic                         busy,
  output logic [$clog2(WIDTH+1)-1:0]   bit_cnt,
  output logic                         par_valid,
  output logic                         par_bit
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Fold one bit into the running parity.
  function automatic logic fold_bit(input logic acc, input logic b);
    return acc ^ b;
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             par_valid_q, par_valid_d;
  logic             par_bit_q, par_bit_d;
`ifdef PARITY_CHECK_EN
  logic             in_par_q, in_par_d;
  logic             par_err_q, par_err_d;
`endif

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    par_valid_d = 1'b0;
    par_bit_d   = par_bit_q;
`ifdef PARITY_CHECK_EN
    in_par_d    = in_par_q;
    par_err_d   = par_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sreg_d  = in_data;
          acc_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
`ifdef PARITY_CHECK_EN
          in_par_d = in_par;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        acc_d  = fold_bit(acc_q, sreg_q[0]);
        sreg_d = sreg_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          // Last bit: publish the folded parity alongside the pulse.
          state_d     = ST_DONE;
          par_bit_d   = fold_bit(acc_q, sreg_q[0]);
          par_valid_d = 1'b1;
`ifdef PARITY_CHECK_EN
          par_err_d   = fold_bit(acc_q, sreg_q[0]) ^ in_par_q;
`endif
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        // Counter holds at WIDTH; par_valid drops on this exit edge.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sreg_q      <= '0;
      acc_q       <= 1'b0;
      cnt_q       <= '0;
      par_valid_q <= 1'b0;
      par_bit_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
      in_par_q    <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      par_valid_q <= par_valid_d;
      par_bit_q   <= par_bit_d;
`ifdef PARITY_CHECK_EN
      in_par_q    <= in_par_d;
      par_err_q   <= par_err_d;
`endif
    end
  end

  // Outputs decode directly from registered state.
  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign ser_bit   = (state_q == ST_SHIFT) & sreg_q[0];
  assign bit_cnt   = cnt_q;
  assign par_valid = par_valid_q;
  assign par_bit   = par_bit_q;
`ifdef PARITY_CHECK_EN
  assign par_err   = par_err_q;
`endif

endmodule

// File: tb/tb_serial_parity_unit.sv
// Directed self-checking bench for serial_parity_unit (WIDTH = 8).
module tb_serial_parity_unit;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       ser_bit;
  logic       busy;
  logic [3:0] bit_cnt;
  logic       par_valid;
  logic       par_bit;
`ifdef PARITY_CHECK_EN
  logic       in_par;
  logic       par_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  serial_parity_unit #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef PARITY_CHECK_EN
    .in_par    (in_par),
    .par_err   (par_err),
`endif
    .ser_bit   (ser_bit),
    .busy      (busy),
    .bit_cnt   (bit_cnt),
    .par_valid (par_valid),
    .par_bit   (par_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling / driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a word in IDLE and take the acceptance edge; in_valid drops after.
  task automatic accept(input logic [7:0] data);
    in_valid = 1'b1;
    in_data  = data;
    step();
    in_valid = 1'b0;
  endtask

  // Called right after the acceptance edge: checks the serial stream, the
  // completion pulse and the return to IDLE. With ignore set, a competing
  // word 8'hFF is offered during SHIFT/DONE and must have no effect.
  task automatic finish_word(input logic [7:0] data, input logic exp_par,
                             input logic ignore, input string name);
    int pulses;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (ser_bit !== data[k]) begin
        n_err++;
        $display("FAIL %s ser_bit[%0d]: got %b expected %b", name, k, ser_bit, data[k]);
      end
      n_cmp++;
      if (bit_cnt !== 4'(k)) begin
        n_err++;
        $display("FAIL %s bit_cnt@%0d: got %0d expected %0d", name, k, bit_cnt, k);
      end
      if (par_valid) pulses++;
      if (ignore && k == 3) begin
        in_valid = 1'b1;
        in_data  = 8'hFF;
      end
      step();
    end
    // Cycle after edge 8: DONE.
    n_cmp++;
    if (par_valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s par_valid: got %b expected 1", name, par_valid);
    end
    n_cmp++;
    if (par_bit !== exp_par) begin
      n_err++;
      $display("FAIL %s par_bit: got %b expected %b", name, par_bit, exp_par);
    end
    n_cmp++;
    if (bit_cnt !== 4'd8 || busy !== 1'b1 || in_ready !== 1'b0 || ser_bit !== 1'b0) begin
      n_err++;
      $display("FAIL %s done_state: got cnt=%0d busy=%b rdy=%b ser=%b expected 8 1 0 0",
               name, bit_cnt, busy, in_ready, ser_bit);
    end
    if (par_valid) pulses++;
    if (ignore) in_valid = 1'b0;
    step();
    // Cycle after edge 9: back in IDLE, par_bit held.
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || par_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s idle_return: got rdy=%b busy=%b pv=%b expected 1 0 0",
               name, in_ready, busy, par_valid);
    end
    n_cmp++;
    if (par_bit !== exp_par) begin
      n_err++;
      $display("FAIL %s par_bit_hold: got %b expected %b", name, par_bit, exp_par);
    end
    n_cmp++;
    if (pulses != 1) begin
      n_err++;
      $display("FAIL %s pulse_count: got %0d expected 1", name, pulses);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    step();
    step();
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || bit_cnt !== 4'd0 ||
        par_valid !== 1'b0 || par_bit !== 1'b0 || ser_bit !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values: got rdy=%b busy=%b cnt=%0d pv=%b pb=%b ser=%b expected 1 0 0 0 0 0",
               in_ready, busy, bit_cnt, par_valid, par_bit, ser_bit);
    end
    in_valid = 1'b0;
    reset    = 1'b0;
    step();
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: got rdy=%b busy=%b expected 1 0", in_ready, busy);
    end
  endtask

  task automatic test_words();
    accept(8'hA5); finish_word(8'hA5, 1'b0, 1'b0, "A5");
    accept(8'h07); finish_word(8'h07, 1'b1, 1'b0, "07");
    accept(8'h00); finish_word(8'h00, 1'b0, 1'b0, "00");
    accept(8'hFF); finish_word(8'hFF, 1'b0, 1'b0, "FF");
  endtask

  task automatic test_back_to_back();
    accept(8'h01);
    in_valid = 1'b1;
    in_data  = 8'h03;
    finish_word(8'h01, 1'b1, 1'b0, "b2b_01");
    step(); // edge 10: second word accepted
    in_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || bit_cnt !== 4'd0) begin
      n_err++;
      $display("FAIL b2b_accept: got busy=%b rdy=%b cnt=%0d expected 1 0 0", busy, in_ready, bit_cnt);
    end
    finish_word(8'h03, 1'b0, 1'b0, "b2b_03");
  endtask

  task automatic test_mid_reset();
    accept(8'h07); finish_word(8'h07, 1'b1, 1'b0, "pre_rst_07");
    accept(8'hA5);
    step(); step(); step(); // after edge 3: bit_cnt = 3
    n_cmp++;
    if (bit_cnt !== 4'd3) begin
      n_err++;
      $display("FAIL mid_rst_cnt: got %0d expected 3", bit_cnt);
    end
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h80;
    step();
    n_cmp++;
    if (par_valid !== 1'b0 || par_bit !== 1'b0 || bit_cnt !== 4'd0 ||
        in_ready !== 1'b1 || busy !== 1'b0 || ser_bit !== 1'b0) begin
      n_err++;
      $display("FAIL mid_rst_state: got pv=%b pb=%b cnt=%0d rdy=%b busy=%b ser=%b expected 0 0 0 1 0 0",
               par_valid, par_bit, bit_cnt, in_ready, busy, ser_bit);
    end
    reset = 1'b0;
    step(); // in_valid still high with 8'h80: accepted now
    in_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || ser_bit !== 1'b0) begin
      n_err++;
      $display("FAIL post_rst_accept: got busy=%b ser=%b expected 1 0", busy, ser_bit);
    end
    finish_word(8'h80, 1'b1, 1'b0, "post_rst_80");
  endtask

  task automatic test_ignore_busy();
    accept(8'h01); finish_word(8'h01, 1'b1, 1'b1, "ign_01");
    step();
    n_cmp++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || par_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ign_no_accept: got busy=%b rdy=%b pv=%b expected 0 1 0", busy, in_ready, par_valid);
    end
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity_check();
    in_par = 1'b1;
    accept(8'hA5); in_par = 1'b0;
    finish_word(8'hA5, 1'b0, 1'b0, "chk_A5_p1");
    n_cmp++;
    if (par_err !== 1'b1) begin
      n_err++;
      $display("FAIL chk_A5_p1 par_err: got %b expected 1", par_err);
    end
    in_par = 1'b0;
    accept(8'hA5);
    finish_word(8'hA5, 1'b0, 1'b0, "chk_A5_p0");
    n_cmp++;
    if (par_err !== 1'b0) begin
      n_err++;
      $display("FAIL chk_A5_p0 par_err: got %b expected 0", par_err);
    end
    in_par = 1'b1;
    accept(8'h07); in_par = 1'b0;
    finish_word(8'h07, 1'b1, 1'b0, "chk_07_p1");
    n_cmp++;
    if (par_err !== 1'b0) begin
      n_err++;
      $display("FAIL chk_07_p1 par_err: got %b expected 0", par_err);
    end
  endtask
`endif

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
`ifdef PARITY_CHECK_EN
    in_par   = 1'b0;
`endif
    test_reset();
    test_words();
    test_back_to_back();
    test_mid_reset();
    test_ignore_busy();
`ifdef PARITY_CHECK_EN
    test_parity_check();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
